// File: rtl/serial_parity_checker_if.sv
// Bus between the serial line side and the parity checker.
// The master drives the strobe and line; the slave returns the word and status.
interface serial_parity_checker_if #(
   parameter int DATA_W = 4
);
   logic              bit_en;
   logic              serial_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   modport master (
      output bit_en, serial_in,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  bit_en, serial_in,
      output data_out, data_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/serial_parity_checker.sv
// Receive side of the even-parity link.
// Frame format: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// The word is delivered even on error; parity_err/frame_err qualify it.
// Everything advances only on bit_en edges, so strobe spacing does not matter.
module serial_parity_checker #(
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_parity_checker_if.slave bus
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              par_q, par_d;     // running XOR of data bits
   logic [DATA_W-1:0] shreg_q, shreg_d;  // word under assembly
   logic              perr_q, perr_d;    // parity verdict held until the stop bit
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              pe_q, pe_d;
   logic              fe_q, fe_d;
   logic              dv_q, dv_d;

   // State and datapath registers; reset wins over any strobe on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         dout_q  <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         dout_q  <= dout_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         dv_q    <= dv_d;
      end
   end

   // Next-state and next-output logic; everything holds unless strobed,
   // and data_valid defaults low so it can only ever be a one-cycle pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      shreg_d = shreg_q;
      perr_d  = perr_q;
      dout_d  = dout_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      dv_d    = 1'b0;
      if (bus.bit_en) begin
         case (state_q)
            IDLE: begin
               if (!bus.serial_in) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  par_d   = 1'b0;
               end
            end
            DATA: begin
               shreg_d[cnt_q] = bus.serial_in;
               par_d          = par_q ^ bus.serial_in;
               if (cnt_q == CNT_LAST) state_d = PARITY;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            PARITY: begin
               perr_d  = par_q ^ bus.serial_in;
               state_d = STOP;
            end
            STOP: begin
               // Outputs change only here, so they never move mid-frame.
               dout_d  = shreg_q;
               pe_d    = perr_q;
               fe_d    = ~bus.serial_in;
               dv_d    = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dv_q;
   assign bus.parity_err = pe_q;
   assign bus.frame_err  = fe_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker (DATA_W = 4).
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_parity_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   dv_cnt   = 0;
   int   busy_cnt = 0;
   int   last_dv  = 0;
   int   prev_dv  = 0;

   serial_parity_checker_if #(.DATA_W(4)) bus ();

   serial_parity_checker #(.DATA_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse / busy bookkeeping seen on every falling edge.
   always @(negedge clk) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.data_valid === 1'b1) begin
         dv_cnt++;
         prev_dv = last_dv;
         last_dv = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One strobed bit, then gap idle cycles without strobe. Starts and ends on a negedge.
   task automatic drive_bit(input logic b, input int gap);
      bus.bit_en = 1'b1; bus.serial_in = b;
      @(negedge clk);
      bus.bit_en = 1'b0; bus.serial_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_body(input logic [3:0] d, input logic p, input logic s, input int gap);
      for (int i = 0; i < 4; i++) drive_bit(d[i], gap);
      drive_bit(p, gap);
      bus.bit_en = 1'b1; bus.serial_in = s;
      @(negedge clk);
      bus.bit_en = 1'b0; bus.serial_in = 1'b1;
   endtask

   task automatic check_word(input string tag, input logic [3:0] d, input logic pe, input logic fe);
      n_checks++;
      if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL %s dv: got %b expected 1", tag, bus.data_valid); end
      n_checks++;
      if (bus.data_out !== d) begin n_fail++; $display("FAIL %s data_out: got %b expected %b", tag, bus.data_out, d); end
      n_checks++;
      if (bus.parity_err !== pe) begin n_fail++; $display("FAIL %s parity_err: got %b expected %b", tag, bus.parity_err, pe); end
      n_checks++;
      if (bus.frame_err !== fe) begin n_fail++; $display("FAIL %s frame_err: got %b expected %b", tag, bus.frame_err, fe); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy after stop: got %b expected 0", tag, bus.busy); end
   endtask

   task automatic test_reset;
      bus.bit_en = 1'b0; bus.serial_in = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.data_out !== 4'b0000) begin n_fail++; $display("FAIL reset data_out: got %b expected 0000", bus.data_out); end
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset dv: got %b expected 0", bus.data_valid); end
      n_checks++;
      if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset parity_err: got %b expected 0", bus.parity_err); end
      n_checks++;
      if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b expected 0", bus.frame_err); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_good_frame;
      dv_cnt = 0; busy_cnt = 0;
      drive_bit(1'b0, 0);
      send_body(4'b1010, 1'b0, 1'b1, 0);
      check_word("good", 4'b1010, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL good dv width: got %b expected 0", bus.data_valid); end
      n_checks++;
      if (dv_cnt !== 1) begin n_fail++; $display("FAIL good pulse count: got %0d expected 1", dv_cnt); end
      n_checks++;
      if (busy_cnt !== 6) begin n_fail++; $display("FAIL good busy cycles: got %0d expected 6", busy_cnt); end
   endtask

   task automatic test_parity_err;
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      drive_bit(1'b0, 0);
      // Previous word must hold while this frame is in flight.
      n_checks++;
      if (bus.data_out !== 4'b1010) begin n_fail++; $display("FAIL hold data_out: got %b expected 1010", bus.data_out); end
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midframe busy: got %b expected 1", bus.busy); end
      drive_bit(1'b0, 0);
      drive_bit(1'b0, 0);
      drive_bit(1'b0, 0);
      bus.bit_en = 1'b1; bus.serial_in = 1'b1;
      @(negedge clk);
      bus.bit_en = 1'b0;
      check_word("parity", 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_frame_err;
      drive_bit(1'b0, 0);
      send_body(4'b1101, 1'b1, 1'b0, 0);
      check_word("framing", 4'b1101, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_idle_slow;
      dv_cnt = 0;
      repeat (10) drive_bit(1'b1, 0);
      n_checks++;
      if (dv_cnt !== 0) begin n_fail++; $display("FAIL idle pulses: got %0d expected 0", dv_cnt); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle busy: got %b expected 0", bus.busy); end
      n_checks++;
      if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL idle hold frame_err: got %b expected 1", bus.frame_err); end
      drive_bit(1'b0, 2);
      send_body(4'b1111, 1'b0, 1'b1, 2);
      check_word("slow", 4'b1111, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL slow dv width: got %b expected 0", bus.data_valid); end
      n_checks++;
      if (dv_cnt !== 1) begin n_fail++; $display("FAIL slow pulse count: got %0d expected 1", dv_cnt); end
   endtask

   task automatic test_back_to_back;
      dv_cnt = 0;
      drive_bit(1'b0, 0);
      send_body(4'b0000, 1'b0, 1'b1, 0);
      check_word("b2b first", 4'b0000, 1'b0, 1'b0);
      // Start bit on the very next strobe; bit_en stays high through the pulse cycle.
      drive_bit(1'b0, 0);
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b dv width: got %b expected 0", bus.data_valid); end
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b start accepted: got busy %b expected 1", bus.busy); end
      send_body(4'b0111, 1'b1, 1'b1, 0);
      check_word("b2b second", 4'b0111, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (dv_cnt !== 2) begin n_fail++; $display("FAIL b2b pulse count: got %0d expected 2", dv_cnt); end
      n_checks++;
      if (last_dv - prev_dv !== 7) begin n_fail++; $display("FAIL b2b spacing: got %0d expected 7", last_dv - prev_dv); end
   endtask

   task automatic test_reset_midframe;
      dv_cnt = 0;
      drive_bit(1'b0, 0);
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      // Reset coincides with a strobe carrying a 0; reset must win.
      rst = 1'b1; bus.bit_en = 1'b1; bus.serial_in = 1'b0;
      @(negedge clk);
      rst = 1'b0; bus.bit_en = 1'b0; bus.serial_in = 1'b1;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst busy: got %b expected 0", bus.busy); end
      n_checks++;
      if (bus.data_out !== 4'b0000) begin n_fail++; $display("FAIL rst data_out: got %b expected 0000", bus.data_out); end
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL rst dv: got %b expected 0", bus.data_valid); end
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b00) begin n_fail++; $display("FAIL rst flags: got %b expected 00", {bus.parity_err, bus.frame_err}); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (dv_cnt !== 0) begin n_fail++; $display("FAIL rst pulses: got %0d expected 0", dv_cnt); end
      drive_bit(1'b0, 0);
      send_body(4'b0110, 1'b0, 1'b1, 0);
      check_word("after rst", 4'b0110, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (dv_cnt !== 1) begin n_fail++; $display("FAIL after rst pulse count: got %0d expected 1", dv_cnt); end
   endtask

   initial begin
      bus.bit_en = 1'b0;
      bus.serial_in = 1'b1;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_parity_err();
      test_frame_err();
      test_idle_slow();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive side of the team's even-parity link. Deserializes a framed bit stream and rebuilds the DATA_W-bit word. Recomputes even parity over the data bits and compares it with the transmitted parity bit. Presents the word with parity and framing status flags. It sits between the serial line and downstream logic that consumes words produced by the even-parity generator at the far end.

## Interface
- DATA_W, default 4: data bits per frame (≥1).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- bit_en  input  1  bit strobe; serial_in is sampled only on edges where bit_en=1.
- serial_in  input  1  serial line; idles high.
- data_out  output  DATA_W  last received word, LSB = first data bit.
- data_valid  output  1  one-cycle pulse per completed frame.
- parity_err  output  1  1 = received parity ≠ even parity of data_out.
- frame_err  output  1  1 = stop bit sampled as 0.
- busy  output  1  1 whenever state ≠ IDLE.

## Operation
- Frame format: start (0), DATA_W data bits LSB first, parity bit, stop (1).
- Even parity: the XOR of the data bits and the parity bit must equal 0.
- FSM states: IDLE, DATA, PARITY, STOP. It advances only on edges with bit_en=1. With bit_en=0, state, counter and registers hold.
- IDLE:
  - bit_en=1 and serial_in=0: go to DATA. Clear bit counter and running parity to 0.
  - bit_en=1 and serial_in=1: stay in IDLE.
- DATA: each strobe writes serial_in into shift register position cnt and XORs it into the running parity. When cnt=DATA_W-1, go to PARITY; otherwise cnt+1.
  - cnt width is clog2(DATA_W), minimum 1.
- PARITY: on the strobe, store perr = running_parity ^ serial_in, then go to STOP.
- STOP: on the strobe, load data_out ← shift register, parity_err ← perr, frame_err ← ~serial_in. Assert data_valid and return to IDLE.
- The word is always delivered, even with errors. The flags qualify it.
- data_out, parity_err and frame_err hold their values until the next frame completes. They do not change mid-frame.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted. No idle gap is required.
- Reset (synchronous):
  - State returns to IDLE; cnt and running parity clear.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - A reset mid-frame discards the partial frame and produces no data_valid.
  - rst has priority over bit_en on the same edge.

## Timing
- Sampling is synchronous: serial_in is registered on the rising edge where bit_en=1. Nothing is sampled asynchronously.
- One frame takes DATA_W+3 strobes.
- busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- data_valid is high for exactly the one clock cycle following the stop-bit edge. It is low otherwise, including when bit_en stays high into that cycle.
- All outputs are registered. There is no combinational path from serial_in or bit_en to any output.
- Latency: outputs update on the stop-bit sampling edge, which is strobe DATA_W+3 of the frame.
- Strobes may be spaced arbitrarily, one per cycle minimum. Behaviour depends only on the sequence of strobed samples.

## Test plan
- Reset, then strobes every cycle, frame 0,{0,1,0,1},0,1 (data 4'b1010, parity 0) -> one data_valid pulse; data_out=4'b1010, parity_err=0, frame_err=0; busy high for 6 cycles.
- Frame 0,{1,0,0,0},0,1 (data 4'b0001, wrong parity 0) -> data_out=4'b0001, parity_err=1, frame_err=0.
- Frame 0,{1,0,1,1},1,0 (data 4'b1101, correct parity, bad stop) -> data_out=4'b1101, parity_err=0, frame_err=1.
- Idle line high with strobes for 10 cycles, then frame 4'b1111 parity 0 with bit_en=1 only every third cycle -> no pulse during idle; then data_out=4'b1111, no errors, data_valid exactly 1 cycle wide.
- Two frames back to back (4'b0000 p0, then 4'b0111 p1) -> two pulses DATA_W+3 strobes apart; second data_out=4'b0111, no errors.
- Assert rst after the 2nd data bit of a frame -> next cycle busy=0, all outputs 0, no data_valid. A subsequent full frame 4'b0110 p0 is received correctly.
